// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the MEM stage and the data memory responder.
// Handshake: a transfer happens on a rising edge where valid && ready are both high; the sender holds payload stable until then.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  mem_ctrl;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rd_data;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, mem_ctrl, funct3, address, wdata, rsp_ready,
    input  req_ready, rsp_valid, rd_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, mem_ctrl, funct3, address, wdata, rsp_ready,
    output req_ready, rsp_valid, rd_data, rsp_err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM serving RV32I byte/half/word loads and stores after a fixed latency.
// One access in flight at a time: IDLE accepts, WAIT counts down, RESP holds the result until taken.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus,
  output logic [1:0]           state_dbg
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, commit;

  logic [1:0]  op_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rd_data_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [AW-1:0] idx;
  logic [31:0]   word, load_val, wmask, wrep, new_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // mem_ctrl=00 is a pipeline bubble, not a request
        if (bus.req_valid && bus.mem_ctrl != 2'b00) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign idx    = addr_q[AW+1:2];
  assign word   = mem[idx];
  assign byte_v = word[{addr_q[1:0], 3'b000} +: 8];
  assign half_v = addr_q[1] ? word[31:16] : word[15:0];

  always_comb begin
    err      = 1'b0;
    load_val = 32'd0;
    wmask    = 32'd0;
    wrep     = 32'd0;
    case (f3_q)
      3'b000: begin
        load_val = {{24{byte_v[7]}}, byte_v};
        wmask    = 32'h0000_00FF << {addr_q[1:0], 3'b000};
        wrep     = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        load_val = {{16{half_v[15]}}, half_v};
        wmask    = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wrep     = {2{wdata_q[15:0]}};
        err      = addr_q[0];
      end
      3'b010: begin
        load_val = word;
        wmask    = 32'hFFFF_FFFF;
        wrep     = wdata_q;
        err      = (addr_q[1:0] != 2'b00);
      end
      3'b100: begin
        load_val = {24'd0, byte_v};
        err      = (op_q == OP_STORE);
      end
      3'b101: begin
        load_val = {16'd0, half_v};
        err      = addr_q[0] | (op_q == OP_STORE);
      end
      default: err = 1'b1;
    endcase
    if (op_q == 2'b11) err = 1'b1;
    if ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) err = 1'b1;
  end

  assign new_word = (word & ~wmask) | (wrep & wmask);

  // RAM has no reset; a reset clears state_q so no commit can follow it
  always_ff @(posedge clk) begin
    if (commit && op_q == OP_STORE && !err) mem[idx] <= new_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 2'b00;
      f3_q      <= 3'b000;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= bus.mem_ctrl;
        f3_q    <= bus.funct3;
        addr_q  <= bus.address;
        wdata_q <= bus.wdata;
      end
      if (commit) begin
        rsp_err_q <= err;
        rd_data_q <= (op_q == OP_LOAD && !err) ? load_val : 32'd0;
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rd_data   = rd_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: byte-addressed reference memory, directed scenarios and randomized loads/stores.
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  mem_b [logic [31:0]];
  logic [32:0] exp_q [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: byte-addressed memory, access rules from the ISA width table.
  function automatic void model_exec(input logic [1:0] c, input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] d, output logic [31:0] rd, output logic e);
    int  size;
    bit  legal;
    rd = 32'd0;
    e  = 1'b0;
    case (f[1:0])
      2'd0: size = 1;
      2'd1: size = 2;
      default: size = 4;
    endcase
    if (c == 2'b01)      legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
    else if (c == 2'b10) legal = (f <= 3'd2);
    else                 legal = 1'b0;
    if (!legal) e = 1'b1;
    else if ((a % 32'(size)) != 0) e = 1'b1;
    else if ((a / 4) >= 32'(DEPTH)) e = 1'b1;
    if (e) return;
    if (c == 2'b10) begin
      for (int i = 0; i < size; i++) mem_b[a + 32'(i)] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_b[a + 32'(i)];
      if (!f[2] && size < 4 && rd[8*size-1]) rd = rd | ~((32'd1 << (8*size)) - 32'd1);
    end
  endfunction

  // Driver: starts and ends at posedge+1; returns response and edges from accept to rsp_valid.
  task automatic run_req(input logic [1:0] c, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input int hold,
                         output logic [31:0] rd, output logic e, output int lat);
    int n;
    bus.req_valid = 1'b1;
    bus.mem_ctrl  = c;
    bus.funct3    = f;
    bus.address   = a;
    bus.wdata     = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mem_ctrl  = 2'b00;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.rsp_valid && lat < 40);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    rd = bus.rd_data;
    e  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.mem_ctrl = 2'b00; bus.funct3 = 3'd0;
    bus.address = 32'd0; bus.wdata = 32'd0; bus.rsp_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    tests_run++; if (bus.rd_data !== 32'd0) begin tests_failed++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
    tests_run++; if (bus.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_init_region();
    logic [31:0] rd, erd; logic e, ee; int lat;
    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom();
      model_exec(2'b10, 3'b010, 32'(w*4), d, erd, ee);
      run_req(2'b10, 3'b010, 32'(w*4), d, 0, rd, e, lat);
      tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL init_sw_err w=%0d got=%b exp=0", w, e); end
      tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL init_sw_lat w=%0d got=%0d exp=%0d", w, lat, LAT); end
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model_exec(2'b10, 3'b010, 32'h10, 32'hDEADBEEF, erd, ee);
    run_req(2'b10, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, e, lat);
    tests_run++; if (lat !== 2 || e !== 1'b0) begin tests_failed++; $display("FAIL t1_sw got lat=%0d err=%b exp lat=2 err=0", lat, e); end
    run_req(2'b01, 3'b010, 32'h10, 32'd0, 0, rd, e, lat);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL t1_lw_lat got=%0d exp=2", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin tests_failed++; $display("FAIL t1_lw got=%h/%b exp=deadbeef/0", rd, e); end
    model_exec(2'b10, 3'b000, 32'h11, 32'h00000080, erd, ee);
    run_req(2'b10, 3'b000, 32'h11, 32'h00000080, 0, rd, e, lat);
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL t2_sb_err got=%b exp=0", e); end
    run_req(2'b01, 3'b000, 32'h11, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== 32'hFFFFFF80) begin tests_failed++; $display("FAIL t2_lb got=%h exp=ffffff80", rd); end
    run_req(2'b01, 3'b100, 32'h11, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== 32'h00000080) begin tests_failed++; $display("FAIL t2_lbu got=%h exp=00000080", rd); end
    run_req(2'b01, 3'b010, 32'h10, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== 32'hDEAD80EF) begin tests_failed++; $display("FAIL t2_lw got=%h exp=dead80ef", rd); end
    run_req(2'b10, 3'b001, 32'h13, 32'h0000AAAA, 0, rd, e, lat);
    tests_run++; if (e !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL t3_sh_misalign got=%h/%b exp=0/1", rd, e); end
    run_req(2'b01, 3'b010, 32'h10, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== 32'hDEAD80EF) begin tests_failed++; $display("FAIL t3_lw_after got=%h exp=dead80ef", rd); end
    run_req(2'b11, 3'b010, 32'h10, 32'd0, 0, rd, e, lat);
    tests_run++; if (e !== 1'b1 || rd !== 32'd0) begin tests_failed++; $display("FAIL t3_reserved got=%h/%b exp=0/1", rd, e); end
    run_req(2'b10, 3'b010, 32'h1000, 32'h55555555, 0, rd, e, lat);
    tests_run++; if (e !== 1'b1) begin tests_failed++; $display("FAIL t5_sw_oor got=%b exp=1", e); end
    model_exec(2'b01, 3'b010, 32'h0, 32'd0, erd, ee);
    run_req(2'b01, 3'b010, 32'h0, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== erd || e !== 1'b0) begin tests_failed++; $display("FAIL t5_lw0 got=%h/%b exp=%h/0", rd, e, erd); end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    int n;
    bus.req_valid = 1'b1; bus.mem_ctrl = 2'b01; bus.funct3 = 3'b010; bus.address = 32'h10;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_ctrl = 2'b00;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
    held = 32'hDEAD80EF;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.mem_ctrl = 2'b01; bus.funct3 = 3'b010; bus.address = 32'h0;
      tests_run++; if (bus.rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL t4_valid i=%0d got=%b exp=1", i, bus.rsp_valid); end
      tests_run++; if (bus.rd_data !== held) begin tests_failed++; $display("FAIL t4_data i=%0d got=%h exp=%h", i, bus.rd_data, held); end
      tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL t4_req_ready i=%0d got=%b exp=0", i, bus.req_ready); end
      tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL t4_busy i=%0d got=%b exp=1", i, bus.busy); end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0; bus.mem_ctrl = 2'b00;
    tests_run++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL t4_no_accept_in_handshake busy=%b ready=%b exp 0/1", bus.busy, bus.req_ready); end
  endtask

  task automatic test_idle_none();
    bus.req_valid = 1'b1; bus.mem_ctrl = 2'b00; bus.funct3 = 3'b010; bus.address = 32'h4;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL none_ignored i=%0d busy=%b rsp_valid=%b exp 0/0", i, bus.busy, bus.rsp_valid); end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model_exec(2'b10, 3'b001, 32'h22, 32'h0000C3A5, erd, ee);
    run_req(2'b10, 3'b001, 32'h22, 32'h0000C3A5, 0, rd, e, lat);
    tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready got=%b exp=1", bus.req_ready); end
    model_exec(2'b01, 3'b001, 32'h22, 32'd0, erd, ee);
    run_req(2'b01, 3'b001, 32'h22, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== erd || lat !== LAT) begin tests_failed++; $display("FAIL b2b_lh got=%h lat=%0d exp=%h lat=%0d", rd, lat, erd, LAT); end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic e, ee; logic [1:0] c; logic [2:0] f; logic [32:0] exp_v; int lat;
    for (int k = 0; k < 150; k++) begin
      c = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(1, 2));
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0: a = 32'h1000 + 32'($urandom_range(0, 255));
        1: a = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        default: a = 32'($urandom_range(0, 63));
      endcase
      d = $urandom();
      model_exec(c, f, a, d, erd, ee);
      exp_q.push_back({ee, erd});
      run_req(c, f, a, d, $urandom_range(0, 3), rd, e, lat);
      exp_v = exp_q.pop_front();
      tests_run++; if (rd !== exp_v[31:0]) begin tests_failed++; $display("FAIL rand_data k=%0d c=%b f=%b a=%h got=%h exp=%h", k, c, f, a, rd, exp_v[31:0]); end
      tests_run++; if (e !== exp_v[32]) begin tests_failed++; $display("FAIL rand_err k=%0d c=%b f=%b a=%h got=%b exp=%b", k, c, f, a, e, exp_v[32]); end
      tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL rand_lat k=%0d got=%0d exp=%0d", k, lat, LAT); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic e, ee; int lat;
    model_exec(2'b01, 3'b010, 32'h20, 32'd0, erd, ee);
    bus.req_valid = 1'b1; bus.mem_ctrl = 2'b10; bus.funct3 = 3'b010;
    bus.address = 32'h20; bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_ctrl = 2'b00;
    reset = 1'b1;
    #1;
    tests_run++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL t6_ready_busy got=%b/%b exp=1/0", bus.req_ready, bus.busy); end
    tests_run++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin tests_failed++; $display("FAIL t6_valid_err got=%b/%b exp=0/0", bus.rsp_valid, bus.rsp_err); end
    tests_run++; if (bus.rd_data !== 32'd0) begin tests_failed++; $display("FAIL t6_rd_data got=%h exp=0", bus.rd_data); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_req(2'b01, 3'b010, 32'h20, 32'd0, 0, rd, e, lat);
    tests_run++; if (rd !== erd || e !== 1'b0) begin tests_failed++; $display("FAIL t6_lw_prestore got=%h/%b exp=%h/0", rd, e, erd); end
  endtask

  initial begin
    test_reset();
    test_init_region();
    test_directed();
    test_hold();
    test_idle_none();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
